// File: rtl/osd_byte_pixel_unpacker_pkg.sv
// Shared types and constants for the OSD byte-to-pixel unpacker.
// Build option: OSD_PIX_LITTLE_ENDIAN_EN selects the payload byte order (see top module).
package osd_pix_pkg;

    typedef enum logic [2:0] {
        S_SYNC0 = 3'd0,
        S_SYNC1 = 3'd1,
        S_HDRH  = 3'd2,
        S_HDRL  = 3'd3,
        S_PIX   = 3'd4
    } parse_state_e;

    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;
    localparam int         RGB565_W  = 16;

    typedef struct packed {
        logic [RGB565_W-1:0] data;
        logic                sof;
        logic                eol;
    } pix_word_t;

endpackage

// File: rtl/osd_byte_pixel_unpacker_if.sv
// Byte-in / pixel-out handshake bundle around the unpacker.
// The master modport is the unpacker side; slave is its FIFO/mixer surroundings.
interface osd_byte_pixel_unpacker_if;
    import osd_pix_pkg::*;

    logic [7:0]          in_data;
    logic                in_vld;
    logic                in_rdy;
    logic [RGB565_W-1:0] pix_data;
    logic                pix_vld;
    logic                pix_rdy;
    logic                pix_sof;
    logic                pix_eol;

    modport master (
        input  in_data,
        input  in_vld,
        output in_rdy,
        output pix_data,
        output pix_vld,
        input  pix_rdy,
        output pix_sof,
        output pix_eol
    );

    modport slave (
        output in_data,
        output in_vld,
        input  in_rdy,
        input  pix_data,
        input  pix_vld,
        output pix_rdy,
        input  pix_sof,
        input  pix_eol
    );

endinterface

// File: rtl/osd_byte_pixel_unpacker_out_reg.sv
// One-entry valid/ready holding register for assembled pixels.
// Upstream ready is asserted whenever the slot is empty or draining this cycle.
module osd_pix_out_reg
    import osd_pix_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_vld,
    input  pix_word_t load_word,
    output logic      load_rdy,
    output logic      out_vld,
    output pix_word_t out_word,
    input  logic      out_rdy
);

    logic      vld_q;
    logic      vld_d;
    pix_word_t word_q;
    pix_word_t word_d;

    always_comb begin
        vld_d    = vld_q;
        word_d   = word_q;
        load_rdy = ~vld_q | out_rdy;
        if (load_vld && load_rdy) begin
            vld_d  = 1'b1;
            word_d = load_word;
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            word_q <= '0;
        end else begin
            vld_q  <= vld_d;
            word_q <= word_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_word = word_q;

endmodule

// File: rtl/osd_byte_pixel_unpacker.sv
// Framed byte stream parser: sync A5 5A, BE line number, H_ACTIVE 2-byte RGB565 pixels.
// Define OSD_PIX_LITTLE_ENDIAN_EN to take the first payload byte as the pixel low byte.
//
// state   | meaning
// S_SYNC0 | hunting for first sync byte
// S_SYNC1 | first sync seen, expecting second
// S_HDRH  | line number high byte
// S_HDRL  | line number low byte
// S_PIX   | pixel payload, two bytes per pixel
module osd_byte_pixel_unpacker
    import osd_pix_pkg::*;
#(
    parameter int         H_ACTIVE = 640,
    parameter logic [7:0] SYNC0    = SYNC0_DEF,
    parameter logic [7:0] SYNC1    = SYNC1_DEF
) (
    input  logic                          rd_clk,
    input  logic                          rd_rst,
    osd_byte_pixel_unpacker_if.master     bus,
    output logic [15:0]                   line_num,
    output logic                          sync_err,
    output logic [15:0]                   err_cnt
);

    localparam logic [11:0] LAST_PIX = 12'(H_ACTIVE - 1);

    parse_state_e state_q, state_d;
    logic [7:0]   first_q, first_d;
    logic         phase_q, phase_d;
    logic [11:0]  pix_cnt_q, pix_cnt_d;
    logic [15:0]  line_num_q, line_num_d;
    logic         locked_q, locked_d;
    logic         sync_err_q, sync_err_d;
    logic [15:0]  err_cnt_q, err_cnt_d;

    logic         in_rdy_c;
    logic         byte_xfer;
    logic         err_hit;
    logic         load_vld;
    logic         load_rdy;
    pix_word_t    load_word;
    pix_word_t    out_word;
    logic         out_vld;

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        phase_d    = phase_q;
        pix_cnt_d  = pix_cnt_q;
        line_num_d = line_num_q;
        locked_d   = locked_q;
        err_cnt_d  = err_cnt_q;
        sync_err_d = 1'b0;
        err_hit    = 1'b0;
        load_vld   = 1'b0;
        load_word  = '0;

        // Only the payload phase can be back-pressured by the output slot.
        in_rdy_c  = (state_q == S_PIX) ? load_rdy : 1'b1;
        byte_xfer = bus.in_vld & in_rdy_c;

        if (byte_xfer) begin
            unique case (state_q)
                S_SYNC0: begin
                    if (bus.in_data == SYNC0) begin
                        state_d = S_SYNC1;
                    end else begin
                        err_hit = locked_q;
                    end
                end
                S_SYNC1: begin
                    if (bus.in_data == SYNC1) begin
                        state_d = S_HDRH;
                    end else if (bus.in_data != SYNC0) begin
                        state_d = S_SYNC0;
                        err_hit = locked_q;
                    end
                end
                S_HDRH: begin
                    line_num_d[15:8] = bus.in_data;
                    state_d          = S_HDRL;
                end
                S_HDRL: begin
                    line_num_d[7:0] = bus.in_data;
                    pix_cnt_d       = '0;
                    phase_d         = 1'b0;
                    state_d         = S_PIX;
                end
                S_PIX: begin
                    if (!phase_q) begin
                        first_d = bus.in_data;
                        phase_d = 1'b1;
                    end else begin
                        load_vld = 1'b1;
`ifdef OSD_PIX_LITTLE_ENDIAN_EN
                        load_word.data = {bus.in_data, first_q};
`else
                        load_word.data = {first_q, bus.in_data};
`endif
                        load_word.sof  = (line_num_q == 16'd0) && (pix_cnt_q == 12'd0);
                        load_word.eol  = (pix_cnt_q == LAST_PIX);
                        phase_d        = 1'b0;
                        if (pix_cnt_q == LAST_PIX) begin
                            state_d  = S_SYNC0;
                            locked_d = 1'b1;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 12'd1;
                        end
                    end
                end
                default: state_d = S_SYNC0;
            endcase
        end

        if (err_hit) begin
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q    <= S_SYNC0;
            first_q    <= '0;
            phase_q    <= 1'b0;
            pix_cnt_q  <= '0;
            line_num_q <= '0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            phase_q    <= phase_d;
            pix_cnt_q  <= pix_cnt_d;
            line_num_q <= line_num_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    osd_pix_out_reg u_out_reg (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .load_vld  (load_vld),
        .load_word (load_word),
        .load_rdy  (load_rdy),
        .out_vld   (out_vld),
        .out_word  (out_word),
        .out_rdy   (bus.pix_rdy)
    );

    assign bus.in_rdy   = in_rdy_c;
    assign bus.pix_vld  = out_vld;
    assign bus.pix_data = out_word.data;
    assign bus.pix_sof  = out_word.sof;
    assign bus.pix_eol  = out_word.eol;
    assign line_num     = line_num_q;
    assign sync_err     = sync_err_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_osd_byte_pixel_unpacker.sv
// Directed bench for osd_byte_pixel_unpacker with H_ACTIVE=4.
// Honours OSD_PIX_LITTLE_ENDIAN_EN for the expected pixel byte order.
module tb_osd_byte_pixel_unpacker;

    localparam int H = 4;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic [15:0] line_num;
    logic        sync_err;
    logic [15:0] err_cnt;

    osd_byte_pixel_unpacker_if bus();

    osd_byte_pixel_unpacker #(.H_ACTIVE(H)) dut (
        .rd_clk   (rd_clk),
        .rd_rst   (rd_rst),
        .bus      (bus),
        .line_num (line_num),
        .sync_err (sync_err),
        .err_cnt  (err_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int n_chk = 0;
    int n_err = 0;
    int err_pulses = 0;

    logic [15:0] qd[$];
    bit          qs[$];
    bit          qe[$];

    // Transfers are recorded half a cycle ahead of the edge that completes them.
    always @(negedge rd_clk) begin
        if (!rd_rst && bus.pix_vld && bus.pix_rdy) begin
            qd.push_back(bus.pix_data);
            qs.push_back(bus.pix_sof);
            qe.push_back(bus.pix_eol);
        end
        if (sync_err) err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] px(input logic [7:0] b0, input logic [7:0] b1);
`ifdef OSD_PIX_LITTLE_ENDIAN_EN
        return {b1, b0};
`else
        return {b0, b1};
`endif
    endfunction

    task automatic clear_q();
        qd.delete();
        qs.delete();
        qe.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.in_data = b;
        bus.in_vld  = 1'b1;
        @(negedge rd_clk);
        while (!bus.in_rdy && t < 200) begin
            @(negedge rd_clk);
            t++;
        end
        if (!bus.in_rdy) chk("in_rdy_timeout", 32'(bus.in_rdy), 32'd1);
        @(posedge rd_clk);
        #1;
        bus.in_vld = 1'b0;
    endtask

    task automatic send_line(input logic [15:0] ln, input logic [63:0] p);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(ln[15:8]);
        send_byte(ln[7:0]);
        for (int i = 0; i < 8; i++) send_byte(p[63-8*i -: 8]);
    endtask

    task automatic check_line(input string tag, input logic [63:0] p, input bit sof0,
                              input logic [15:0] ln);
        logic [7:0] b0, b1;
        chk({tag, "_count"}, 32'(qd.size()), 32'(H));
        for (int i = 0; i < H; i++) begin
            if (i < qd.size()) begin
                b0 = p[63-16*i -: 8];
                b1 = p[55-16*i -: 8];
                chk($sformatf("%s_data%0d", tag, i), 32'(qd[i]), 32'(px(b0, b1)));
                chk($sformatf("%s_sof%0d", tag, i), 32'(qs[i]), 32'(sof0 && i == 0));
                chk($sformatf("%s_eol%0d", tag, i), 32'(qe[i]), 32'(i == H - 1));
            end
        end
        chk({tag, "_line_num"}, 32'(line_num), 32'(ln));
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        int waited;
        logic [15:0] first_pix;

        rd_rst      = 1'b1;
        bus.in_data = 8'h00;
        bus.in_vld  = 1'b0;
        bus.pix_rdy = 1'b1;
        idle(3);
        rd_rst = 1'b0;

        @(negedge rd_clk);
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        chk("rst_pix_vld", 32'(bus.pix_vld), 32'd0);
        chk("rst_pix_data", 32'(bus.pix_data), 32'd0);
        chk("rst_pix_sof", 32'(bus.pix_sof), 32'd0);
        chk("rst_pix_eol", 32'(bus.pix_eol), 32'd0);
        chk("rst_line_num", 32'(line_num), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        idle(1);

        // Basic line 0
        clear_q();
        send_line(16'h0000, 64'h1122334455667788);
        idle(4);
        check_line("basic", 64'h1122334455667788, 1'b1, 16'h0000);

        // Junk before sync while unlocked
        do_reset();
        clear_q();
        err_pulses = 0;
        send_byte(8'h00);
        send_byte(8'hA5);
        send_line(16'h0007, 64'h0102030405060708);
        idle(4);
        check_line("junk", 64'h0102030405060708, 1'b0, 16'h0007);
        chk("junk_no_err", 32'(err_pulses), 32'd0);

        // Loss of lock at first sync byte, then relock
        send_byte(8'h3C);
        idle(3);
        chk("lock_err_pulse", 32'(err_pulses), 32'd1);
        chk("lock_err_cnt", 32'(err_cnt), 32'd1);
        clear_q();
        send_line(16'h0003, 64'hA1B2C3D4E5F60718);
        idle(4);
        check_line("relock", 64'hA1B2C3D4E5F60718, 1'b0, 16'h0003);
        chk("relock_err_cnt", 32'(err_cnt), 32'd1);

        // Loss of lock at second sync byte
        send_byte(8'hA5);
        send_byte(8'h77);
        idle(3);
        chk("sync1_err_pulse", 32'(err_pulses), 32'd2);
        chk("sync1_err_cnt", 32'(err_cnt), 32'd2);

        // Output back-pressure for 10 cycles after the first pixel
        clear_q();
        bus.pix_rdy = 1'b0;
        first_pix = px(8'hDE, 8'hAD);
        fork
            send_line(16'h0000, 64'hDEADBEEF12345678);
            begin
                waited = 0;
                @(negedge rd_clk);
                while (!bus.pix_vld && waited < 100) begin
                    @(negedge rd_clk);
                    waited++;
                end
                chk("bp_first_vld", 32'(bus.pix_vld), 32'd1);
                mism = 0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge rd_clk);
                    if (bus.pix_data !== first_pix || bus.pix_vld !== 1'b1) mism++;
                end
                chk("bp_hold_stable", 32'(mism), 32'd0);
                chk("bp_in_rdy_low", 32'(bus.in_rdy), 32'd0);
                @(posedge rd_clk);
                #1;
                bus.pix_rdy = 1'b1;
            end
        join
        idle(4);
        check_line("bp", 64'hDEADBEEF12345678, 1'b1, 16'h0000);

        // Reset after three payload bytes drops the stale first byte
        clear_q();
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h00);
        send_byte(8'h09);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        do_reset();
        @(negedge rd_clk);
        chk("mrst_pix_vld", 32'(bus.pix_vld), 32'd0);
        chk("mrst_in_rdy", 32'(bus.in_rdy), 32'd1);
        chk("mrst_line_num", 32'(line_num), 32'd0);
        chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
        idle(1);
        clear_q();
        send_line(16'h0000, 64'h445566778899AABB);
        idle(4);
        check_line("mrst", 64'h445566778899AABB, 1'b1, 16'h0000);

        // Reset with a pixel held in the output slot discards it
        clear_q();
        bus.pix_rdy = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(2);
        @(negedge rd_clk);
        chk("pend_vld", 32'(bus.pix_vld), 32'd1);
        chk("pend_line_num", 32'(line_num), 32'd5);
        idle(1);
        do_reset();
        @(negedge rd_clk);
        chk("pend_rst_vld", 32'(bus.pix_vld), 32'd0);
        chk("pend_rst_line", 32'(line_num), 32'd0);
        bus.pix_rdy = 1'b1;
        idle(3);
        chk("pend_nothing_out", 32'(qd.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
